// File: rtl/bru_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bru_update_ctrl
// Brief    : Prediction queue and resolver. Compares each fetch-order BTB
//            prediction with the back-end outcome, then drives the BTB write
//            port and a one-cycle redirect/flush on every mispredict.
//            Define BRU_PERF_CNT_EN to build the branch/mispredict counters.
// Revision : 1.0 - initial release
// ============================================================================
module bru_update_ctrl #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_valid,
  output logic        push_ready,
  input  logic [31:0] push_pc,
  input  logic        push_taken,
  input  logic [31:0] push_target,
  input  logic        res_valid,
  output logic        res_ready,
  input  logic [31:0] res_pc,
  input  logic        res_is_branch,
  input  logic        res_taken,
  input  logic [31:0] res_target,
  output logic        update_en,
  output logic [31:0] pc_dispatch,
  output logic [31:0] pc_actual,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt
);

  localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [31:0]   r_q_pc     [DEPTH];
  logic          r_q_taken  [DEPTH];
  logic [31:0]   r_q_target [DEPTH];

  logic [c_AW:0]   r_wr_ptr;
  logic [c_AW:0]   r_rd_ptr;
  logic [c_AW-1:0] w_wr_idx;
  logic [c_AW-1:0] w_rd_idx;
  logic            w_full;
  logic            w_empty;
  logic            w_push_fire;
  logic            w_res_fire;

  logic [31:0] w_h_pc;
  logic        w_h_taken;
  logic [31:0] w_h_target;
  logic [31:0] w_next_pc;
  logic        w_mispred;
  logic        w_need_update;
  logic        w_flush_now;

  logic        r_update_en;
  logic [31:0] r_pc_dispatch;
  logic [31:0] r_pc_actual;
  logic        r_redirect_valid;
  logic [31:0] r_redirect_pc;

  assign w_wr_idx = r_wr_ptr[c_AW-1:0];
  assign w_rd_idx = r_rd_ptr[c_AW-1:0];
  assign w_full   = (w_wr_idx == w_rd_idx) && (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]);
  assign w_empty  = (r_wr_ptr == r_rd_ptr);

  // No bypass in either direction: readiness depends only on registered state.
  assign push_ready  = !w_full && (r_state == ST_RUN);
  assign res_ready   = !w_empty && (r_state == ST_RUN);
  assign w_push_fire = push_valid && push_ready;
  assign w_res_fire  = res_valid && res_ready;

  assign w_h_pc     = r_q_pc[w_rd_idx];
  assign w_h_taken  = r_q_taken[w_rd_idx];
  assign w_h_target = r_q_target[w_rd_idx];

  assign w_next_pc = res_taken ? res_target : (res_pc + 32'd4);

  assign w_mispred = (w_h_taken != (res_is_branch && res_taken)) ||
                     (res_taken && (w_h_target != res_target)) ||
                     (w_h_pc != res_pc);

  // The BTB cannot invalidate, so only taken branches with a missing or
  // stale target are written back.
  assign w_need_update = res_is_branch && res_taken &&
                         (!w_h_taken || (w_h_target != res_target));

  assign w_flush_now = w_res_fire && w_mispred;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (w_flush_now) w_state_nxt = ST_FLUSH;
      ST_FLUSH: w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || w_flush_now) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_fire) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_res_fire) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_fire) begin
      r_q_pc[w_wr_idx]     <= push_pc;
      r_q_taken[w_wr_idx]  <= push_taken;
      r_q_target[w_wr_idx] <= push_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_update_en      <= 1'b0;
      r_pc_dispatch    <= '0;
      r_pc_actual      <= '0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      r_update_en      <= w_res_fire && w_need_update;
      r_redirect_valid <= w_flush_now;
      if (w_res_fire && w_need_update) begin
        r_pc_dispatch <= res_pc;
        r_pc_actual   <= res_target;
      end
      if (w_flush_now) begin
        r_redirect_pc <= w_next_pc;
      end
    end
  end

  assign update_en      = r_update_en;
  assign pc_dispatch    = r_pc_dispatch;
  assign pc_actual      = r_pc_actual;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;

`ifdef BRU_PERF_CNT_EN
  logic [31:0] r_branch_cnt;
  logic [31:0] r_mispred_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (w_res_fire && res_is_branch) begin
        r_branch_cnt <= r_branch_cnt + 32'd1;
      end
      if (w_flush_now) begin
        r_mispred_cnt <= r_mispred_cnt + 32'd1;
      end
    end
  end

  assign branch_cnt  = r_branch_cnt;
  assign mispred_cnt = r_mispred_cnt;
`else
  assign branch_cnt  = '0;
  assign mispred_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: doc/bru_update_ctrl.md
# bru_update_ctrl

Branch-resolution side of the front-end predictor: it holds, in fetch order, every prediction the BTB lookup issued, and compares each against the actual outcome reported by the back end. It drives the BTB write port (`update_en`, `pc_dispatch`, `pc_actual`) and produces a one-cycle fetch redirect plus a prediction-queue flush on every mispredict. It sits between the fetch stage, which pushes predictions, and the execute/branch unit, which pops resolutions.

## Interface
Parameters:
- `DEPTH`, default 8: prediction queue entries; power of two, 2 to 64.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset rst, synchronous, active-high; clock clk
- `push_valid`  in  1  fetch pushes one prediction
- `push_ready`  out  1  queue can accept
- `push_pc`  in  32  PC of predicted instruction
- `push_taken`  in  1  predicted taken (BTB hit)
- `push_target`  in  32  predicted target
- `res_valid`  in  1  back end presents one resolved instruction, in program order
- `res_ready`  out  1  resolution accepted
- `res_pc`  in  32  resolved PC
- `res_is_branch`  in  1  instruction is a control-transfer
- `res_taken`  in  1  actual direction
- `res_target`  in  32  actual target
- `update_en`  out  1  BTB write strobe
- `pc_dispatch`  out  32  BTB write PC
- `pc_actual`  out  32  BTB write target
- `redirect_valid`  out  1  fetch redirect pulse
- `redirect_pc`  out  32  correct next fetch PC
- `branch_cnt`  out  32  resolved branches (perf)
- `mispred_cnt`  out  32  mispredicts (perf)

## Operation
- Queue: circular buffer of `DEPTH` entries {pc, taken, target}; read/write pointers carry an extra wrap bit; full when indices are equal and wrap bits differ, empty when both are equal.
- `push_ready` = !full && state==RUN. `res_ready` = !empty && state==RUN. No bypass: an empty queue never accepts a resolution, and a full queue rejects a push even while popping.
- On resolution handshake: pop head H; `next = res_taken ? res_target : res_pc + 4` (32-bit wrap).
- Mispredict = (H.taken != (res_is_branch && res_taken)) || (res_taken && H.target != res_target) || (H.pc != res_pc).
- BTB update when `res_is_branch && res_taken && (!H.taken || H.target != res_target)`: `pc_dispatch`=res_pc, `pc_actual`=res_target. Predicted-taken non-branch or not-taken branch: no update (BTB has no invalidate).
- On mispredict: `redirect_pc`=next; all queue entries are discarded, including a push accepted in the same cycle; state moves RUN→FLUSH.
- States: RUN (normal); FLUSH (exactly one cycle, both readies 0, pointers reset to empty) → RUN.
- Update and redirect can occur together (taken branch with wrong or missing target).

## Timing
- Reset: `update_en`, `redirect_valid`=0; `pc_dispatch`, `pc_actual`, `redirect_pc`=0; counters 0; queue empty; state RUN; `push_ready`=1, `res_ready`=0 in the first cycle after reset.
- `update_en`/`redirect_valid` are registered one-cycle pulses, asserted in the cycle after the resolution handshake; data outputs hold their value until the next update/redirect.
- A push becomes poppable in the cycle after it is accepted.
- Back-to-back resolutions: one per cycle while RUN, no bubbles unless mispredicted.
- `rst` mid-operation: queue cleared and any pending pulse suppressed in the same edge.

## Configuration
- `BRU_PERF_CNT_EN` defined: `branch_cnt` increments on every handshake with `res_is_branch`=1; `mispred_cnt` increments on every mispredict; both wrap at 2^32 and are cleared by reset.
- Not defined: counter logic is absent; both ports are tied to 0.

## Test plan
- Push {0x1C000000, taken=0}; resolve pc 0x1C000000, non-branch → no update, no redirect, queue empty next cycle.
- Push {0x1C000010, taken=0}; resolve branch taken to 0x1C000100 → next cycle `update_en`=1, `pc_dispatch`=0x1C000010, `pc_actual`=0x1C000100, `redirect_pc`=0x1C000100, one FLUSH cycle with both readies 0.
- Push {0x1C000020, taken=1, target=0x1C000200}; resolve taken to 0x1C000200 → no pulses; with the macro defined `branch_cnt`=1, `mispred_cnt`=0.
- Push {0x1C000030, taken=1}; resolve branch not taken → redirect to 0x1C000034, `update_en`=0; three younger queued entries are dropped.
- Fill `DEPTH` entries → `push_ready`=0; pop one with a simultaneous push → push rejected; next cycle `push_ready`=1.
- Assert `rst` in the same cycle as a mispredicting resolution → no redirect pulse, queue empty, all outputs 0.
